start_point_seq: RTL and testbench

Trial-level starting-point sequencer for the hippocampal navigation network. It replaces the fixed per-trial lookup with a parametrised generator. On each trial request it selects a starting point, either sequentially or LFSR-shuffled, with a configurable repeat factor. It drives a one-hot {axis, position} vector onto the Layer-1 input for a programmable presentation window, then signals trial completion to the trial controller.

---
 rtl/start_point_seq.sv | 157 +++++++++++++++
 tb/tb_start_point_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/start_point_seq.sv
// start_point_seq: per-trial starting-point generator (sequential or LFSR codes with repeat factor)
// driving a one-hot {axis, position} vector for a programmable window. Option: SP_NO_REPEAT_EN.
module start_point_seq #(
  parameter int                AXIS_W  = 2,
  parameter int                POS_W   = 4,
  parameter int                N_OUT   = AXIS_W + POS_W,
  parameter int                MODE    = 1,
  parameter int                REPEAT  = 2,
  parameter int                LFSR_W  = 10,
  parameter logic [LFSR_W-1:0] TAPS    = 10'b1001000000,
  parameter logic [LFSR_W-1:0] SEED    = 10'b1110110101,
  parameter int                HOLD_W  = 16,
  parameter int                TRIAL_W = 10
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 active,
  input  logic                                 trial_start,
  input  logic                                 seed_load,
  input  logic [LFSR_W-1:0]                    seed,
  input  logic [HOLD_W-1:0]                    hold_cyc,
  output logic [N_OUT-1:0]                     InVec,
  output logic                                 vec_valid,
  output logic                                 trial_done,
  output logic                                 busy,
  output logic [$clog2(AXIS_W*POS_W)-1:0]      code,
  output logic [TRIAL_W-1:0]                   trial_cnt
);

  localparam int CODE_W = $clog2(AXIS_W * POS_W);
  localparam int PS_W   = $clog2(POS_W);
  localparam int REP_W  = (REPEAT > 1) ? $clog2(REPEAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_PRESENT} state_t;

  state_t              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q;
  logic [CODE_W-1:0]   seq_ptr_q;
  logic [CODE_W-1:0]   code_q;
  logic [REP_W-1:0]    rep_cnt_q;
  logic                has_prev_q;
  logic                drawn_q;
  logic [HOLD_W-1:0]   hold_q;
  logic                trial_done_q;
  logic [TRIAL_W-1:0]  trial_cnt_q;

  logic [LFSR_W-1:0]   lfsr_step, lfsr_adv;
  logic [CODE_W-1:0]   cand;
  logic                reuse, reject;
  logic [HOLD_W-1:0]   hold_eff;

  // Fibonacci step: shift left, parity of tapped bits enters at the LSB.
  assign lfsr_step = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
  assign lfsr_adv  = (lfsr_step == '0) ? SEED : lfsr_step;
  assign cand      = lfsr_adv[CODE_W-1:0];
  assign reuse     = (rep_cnt_q != '0) && has_prev_q;
  assign hold_eff  = (hold_cyc == '0) ? HOLD_W'(1) : hold_cyc;

`ifdef SP_NO_REPEAT_EN
  assign reject = (MODE == 1) && has_prev_q && (cand == code_q);
`else
  assign reject = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: state_d is assigned before the case so every path has a value and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (!seed_load && trial_start && active) state_d = S_DRAW;
      S_DRAW:    if (!active) state_d = S_IDLE;
                 else if (drawn_q) state_d = S_PRESENT;
      S_PRESENT: if (!active || hold_q == HOLD_W'(1)) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q       <= SEED;
      seq_ptr_q    <= '0;
      code_q       <= '0;
      rep_cnt_q    <= '0;
      has_prev_q   <= 1'b0;
      drawn_q      <= 1'b0;
      hold_q       <= HOLD_W'(1);
      trial_done_q <= 1'b0;
      trial_cnt_q  <= '0;
    end else begin
      trial_done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (seed_load) begin
            lfsr_q      <= (seed == '0) ? SEED : seed;
            seq_ptr_q   <= '0;
            rep_cnt_q   <= '0;
            trial_cnt_q <= '0;
            has_prev_q  <= 1'b0;
          end else if (trial_start && active) begin
            hold_q  <= hold_eff;
            drawn_q <= 1'b0;
          end
        end
        S_DRAW: begin
          // The accepted code is registered first and presented from the register next cycle.
          if (active && !drawn_q) begin
            if (reuse) begin
              drawn_q <= 1'b1;
            end else if (MODE == 0) begin
              code_q     <= seq_ptr_q;
              seq_ptr_q  <= seq_ptr_q + CODE_W'(1);
              has_prev_q <= 1'b1;
              drawn_q    <= 1'b1;
            end else begin
              lfsr_q <= lfsr_adv;
              if (!reject) begin
                code_q     <= cand;
                has_prev_q <= 1'b1;
                drawn_q    <= 1'b1;
              end
            end
          end
        end
        S_PRESENT: begin
          if (active) begin
            if (hold_q == HOLD_W'(1)) begin
              trial_done_q <= 1'b1;
              trial_cnt_q  <= trial_cnt_q + TRIAL_W'(1);
              rep_cnt_q    <= (rep_cnt_q == REP_W'(REPEAT - 1)) ? '0 : rep_cnt_q + REP_W'(1);
            end else begin
              hold_q <= hold_q - HOLD_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  logic [AXIS_W-1:0] axis_oh;
  logic [POS_W-1:0]  pos_oh;

  assign axis_oh    = AXIS_W'(1) << code_q[CODE_W-1:PS_W];
  assign pos_oh     = POS_W'(1) << code_q[PS_W-1:0];
  assign vec_valid  = (state_q == S_PRESENT);
  assign busy       = (state_q != S_IDLE);
  assign InVec      = vec_valid ? N_OUT'({axis_oh, pos_oh}) : '0;
  assign trial_done = trial_done_q;
  assign code       = code_q;
  assign trial_cnt  = trial_cnt_q;

endmodule

// File: tb/tb_start_point_seq.sv
// Self-checking bench for start_point_seq: three instances (sequential/REPEAT=2, LFSR/REPEAT=2,
// LFSR/REPEAT=1) checked against a trial-level reference model of code choice and timing.
module tb_start_point_seq;

  localparam logic [9:0] TAPS = 10'b1001000000;
  localparam logic [9:0] SEED = 10'b1110110101;
`ifdef SP_NO_REPEAT_EN
  localparam bit NO_REP = 1'b1;
`else
  localparam bit NO_REP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        act    [3];
  logic        ts     [3];
  logic        sl     [3];
  logic [9:0]  seed_v [3];
  logic [15:0] hold_v [3];
  logic [5:0]  invec  [3];
  logic        vv     [3];
  logic        td     [3];
  logic        bsy    [3];
  logic [2:0]  code_o [3];
  logic [9:0]  tcnt   [3];

  always #5 clk = ~clk;

  start_point_seq #(.MODE(0), .REPEAT(2)) u0 (
    .clk(clk), .reset(reset), .active(act[0]), .trial_start(ts[0]), .seed_load(sl[0]),
    .seed(seed_v[0]), .hold_cyc(hold_v[0]), .InVec(invec[0]), .vec_valid(vv[0]),
    .trial_done(td[0]), .busy(bsy[0]), .code(code_o[0]), .trial_cnt(tcnt[0]));
  start_point_seq #(.MODE(1), .REPEAT(2)) u1 (
    .clk(clk), .reset(reset), .active(act[1]), .trial_start(ts[1]), .seed_load(sl[1]),
    .seed(seed_v[1]), .hold_cyc(hold_v[1]), .InVec(invec[1]), .vec_valid(vv[1]),
    .trial_done(td[1]), .busy(bsy[1]), .code(code_o[1]), .trial_cnt(tcnt[1]));
  start_point_seq #(.MODE(1), .REPEAT(1)) u2 (
    .clk(clk), .reset(reset), .active(act[2]), .trial_start(ts[2]), .seed_load(sl[2]),
    .seed(seed_v[2]), .hold_cyc(hold_v[2]), .InVec(invec[2]), .vec_valid(vv[2]),
    .trial_done(td[2]), .busy(bsy[2]), .code(code_o[2]), .trial_cnt(tcnt[2]));

  int errors = 0;
  int checks = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: trial-level bookkeeping of which code each trial must present.
  int         mode_of [3] = '{0, 1, 1};
  int         rep_of  [3] = '{2, 2, 1};
  logic [9:0] m_lfsr  [3];
  int         m_ptr   [3];
  int         m_rep   [3];
  int         m_last  [3];
  int         m_cnt   [3];
  bit         m_has   [3];

  function automatic logic [9:0] lfsr_next(logic [9:0] s);
    return {s[8:0], ^(s & TAPS)};
  endfunction

  function automatic logic [31:0] exp_vec(int c);
    return 32'((1 << (4 + c / 4)) | (1 << (c % 4)));
  endfunction

  task automatic model_seed(int i, logic [9:0] s);
    m_lfsr[i] = (s == 10'd0) ? SEED : s;
    m_ptr[i]  = 0;
    m_rep[i]  = 0;
    m_cnt[i]  = 0;
    m_has[i]  = 1'b0;
  endtask

  task automatic model_draw(int i, output int c, output int att);
    if (m_rep[i] != 0 && m_has[i]) begin
      c   = m_last[i];
      att = 1;
    end else if (mode_of[i] == 0) begin
      c        = m_ptr[i];
      m_ptr[i] = (m_ptr[i] + 1) % 8;
      att      = 1;
    end else begin
      att = 0;
      do begin
        m_lfsr[i] = lfsr_next(m_lfsr[i]);
        c         = int'(m_lfsr[i][2:0]);
        att++;
      end while (NO_REP && m_has[i] && c == m_last[i] && att < 100);
    end
    m_last[i] = c;
    m_has[i]  = 1'b1;
  endtask

  task automatic model_complete(int i);
    m_rep[i] = (m_rep[i] + 1) % rep_of[i];
    m_cnt[i] = (m_cnt[i] + 1) % 1024;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a trial from the current cycle (called #1 after an edge) and returns in its trial_done cycle.
  task automatic run_trial(int i, int hold, int poke_at, string tag);
    int c, att, n, v, exp_len;
    model_draw(i, c, att);
    exp_len   = (hold == 0) ? 1 : hold;
    ts[i]     = 1'b1;
    hold_v[i] = 16'(hold);
    tick();
    ts[i] = 1'b0;
    check({tag, ".busy"}, 32'(bsy[i]), 32'd1);
    n = 0;
    while (!vv[i] && n < 64) begin tick(); n++; end
    check({tag, ".latency"}, 32'(n), 32'(1 + att));
    check({tag, ".code"}, 32'(code_o[i]), 32'(c));
    check({tag, ".invec"}, 32'(invec[i]), exp_vec(c));
    v = 0;
    while (vv[i] && v < 1000) begin
      ts[i] = (v == poke_at);
      v++;
      tick();
    end
    ts[i] = 1'b0;
    check({tag, ".hold"}, 32'(v), 32'(exp_len));
    model_complete(i);
    check({tag, ".done"}, 32'(td[i]), 32'd1);
    check({tag, ".invec0"}, 32'(invec[i]), 32'd0);
    check({tag, ".tcnt"}, 32'(tcnt[i]), 32'(m_cnt[i]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, att, n;
    logic [9:0] s;
    for (int i = 0; i < 3; i++) begin
      act[i] = 1'b1; ts[i] = 1'b0; sl[i] = 1'b0; seed_v[i] = '0; hold_v[i] = '0;
      model_seed(i, SEED);
    end
    reset = 1'b1;
    #12;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst%0d.invec", i), 32'(invec[i]), 32'd0);
      check($sformatf("rst%0d.valid", i), 32'(vv[i]), 32'd0);
      check($sformatf("rst%0d.done", i), 32'(td[i]), 32'd0);
      check($sformatf("rst%0d.busy", i), 32'(bsy[i]), 32'd0);
      check($sformatf("rst%0d.code", i), 32'(code_o[i]), 32'd0);
      check($sformatf("rst%0d.tcnt", i), 32'(tcnt[i]), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Sequential codes, two trials each, chained back to back.
    for (int t = 0; t < 6; t++) run_trial(0, 3, -1, $sformatf("seq%0d", t));
    check("seq.tcnt6", 32'(tcnt[0]), 32'd6);
    tick();

    run_trial(0, 0, -1, "hold0");
    tick();
    // A request during PRESENT is dropped; one in the trial_done cycle starts the next trial.
    run_trial(0, 4, 1, "poke");
    run_trial(0, 2, -1, "b2b");
    tick();
    check("b2b.idle", 32'(bsy[0]), 32'd0);

    // Abort two cycles into PRESENT; the pending repeat must survive.
    model_draw(0, c, att);
    ts[0] = 1'b1; hold_v[0] = 16'd6;
    tick();
    ts[0] = 1'b0;
    n = 0;
    while (!vv[0] && n < 64) begin tick(); n++; end
    check("abort.code", 32'(code_o[0]), 32'(c));
    tick();
    act[0] = 1'b0;
    tick();
    check("abort.invec", 32'(invec[0]), 32'd0);
    check("abort.done", 32'(td[0]), 32'd0);
    check("abort.busy", 32'(bsy[0]), 32'd0);
    check("abort.tcnt", 32'(tcnt[0]), 32'(m_cnt[0]));
    act[0] = 1'b1;
    tick();
    check("abort.done2", 32'(td[0]), 32'd0);
    run_trial(0, 2, -1, "after_abort");
    tick();

    // seed_load and trial_start together: reload wins, request dropped.
    sl[0] = 1'b1; ts[0] = 1'b1; seed_v[0] = 10'd0;
    tick();
    sl[0] = 1'b0; ts[0] = 1'b0;
    model_seed(0, 10'd0);
    check("sl.busy", 32'(bsy[0]), 32'd0);
    check("sl.tcnt", 32'(tcnt[0]), 32'd0);
    run_trial(0, 1, -1, "sl.first");
    tick();

    // LFSR codes from the default seed, each used twice.
    sl[1] = 1'b1; seed_v[1] = 10'd0;
    tick();
    sl[1] = 1'b0;
    model_seed(1, 10'd0);
    for (int t = 0; t < 16; t++) run_trial(1, $urandom_range(0, 3), -1, $sformatf("lfsr%0d", t));
    tick();

    // REPEAT=1 with random seed, holds and gaps.
    s = 10'($urandom_range(1, 1023));
    sl[2] = 1'b1; seed_v[2] = s;
    tick();
    sl[2] = 1'b0;
    model_seed(2, s);
    for (int t = 0; t < 200; t++) begin
      run_trial(2, $urandom_range(0, 2), -1, $sformatf("rnd%0d", t));
      if ($urandom_range(0, 3) == 0) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
